// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiplier/accumulator datapath:
// FSM state encoding and default widths.
package matrix_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/matrix_accumulator_if.sv
// Product stream from the multiplier into the accumulator (valid/ready handshake).
interface matrix_accumulator_if
  import matrix_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              prod_valid;
  logic [DATA_W-1:0] prod_data;
  logic              prod_ready;

  modport master (output prod_valid, output prod_data, input prod_ready);
  modport slave  (input prod_valid, input prod_data, output prod_ready);

endinterface

// File: rtl/acc_result_rf.sv
// Result register file: one synchronous write port with clear-all and one
// registered read port that returns zero for indices beyond N_RESULTS.
module acc_result_rf
  import matrix_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int N_RESULTS = 8,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [N_RESULTS];

  // Read samples the pre-edge contents, so a same-edge write returns the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_RESULTS; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (clear) begin
        for (int i = 0; i < N_RESULTS; i++) mem[i] <= '0;
      end else if (we) begin
        mem[waddr] <= wdata;
      end
      rdata <= (int'(raddr) < N_RESULTS) ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/matrix_accumulator.sv
// Sums each group of TERMS partial products into one result element and
// stores N_RESULTS elements; adder_opdone flags a completed operation.
module matrix_accumulator
  import matrix_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TERMS     = 4,
  parameter int N_RESULTS = 8,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 adder_opstart,
  input  logic                 multi_opclear,
  matrix_accumulator_if.slave  prod,
  input  logic [ADDR_W-1:0]    rAddr,
  output logic [DATA_W-1:0]    result,
  output logic                 adder_opdone,
  output logic                 overflow
);

  localparam int TERM_W = (TERMS > 1) ? $clog2(TERMS) : 1;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc;
  logic [TERM_W-1:0] term_cnt;
  logic [ADDR_W-1:0] elem_cnt;
  logic              ready;
  logic              accept;
  logic              last_term;
  logic              last_elem;
  logic [DATA_W:0]   sum;

  // A pending clear blocks acceptance so the product is not lost into a wiped acc.
  assign ready           = (state == ACCUM) && !multi_opclear;
  assign prod.prod_ready = ready;
  assign accept          = prod.prod_valid && ready;
  assign sum             = {1'b0, acc} + {1'b0, prod.prod_data};
  assign last_term       = (term_cnt == TERM_W'(TERMS - 1));
  assign last_elem       = (elem_cnt == ADDR_W'(N_RESULTS - 1));
  assign adder_opdone    = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (multi_opclear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (adder_opstart) state_nxt = ACCUM;
        ACCUM:   if (accept && last_term && last_elem) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      term_cnt <= '0;
      elem_cnt <= '0;
      overflow <= 1'b0;
    end else if (multi_opclear) begin
      acc      <= '0;
      term_cnt <= '0;
      elem_cnt <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      overflow <= overflow | sum[DATA_W];
      if (last_term) begin
        acc      <= '0;
        term_cnt <= '0;
        elem_cnt <= elem_cnt + ADDR_W'(1);
      end else begin
        acc      <= sum[DATA_W-1:0];
        term_cnt <= term_cnt + TERM_W'(1);
      end
    end
  end

  acc_result_rf #(
    .DATA_W    (DATA_W),
    .N_RESULTS (N_RESULTS),
    .ADDR_W    (ADDR_W)
  ) u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (multi_opclear),
    .we      (accept && last_term),
    .waddr   (elem_cnt),
    .wdata   (sum[DATA_W-1:0]),
    .raddr   (rAddr),
    .rdata   (result)
  );

endmodule

// File: tb/tb_matrix_accumulator.sv
// Directed-vector bench for matrix_accumulator (TERMS=4, N_RESULTS=8, DATA_W=32).
module tb_matrix_accumulator;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              adder_opstart;
  logic              multi_opclear;
  logic [ADDR_W-1:0] rAddr;
  logic [DATA_W-1:0] result;
  logic              adder_opdone;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  matrix_accumulator_if #(.DATA_W(DATA_W)) pif();

  matrix_accumulator #(
    .DATA_W    (DATA_W),
    .TERMS     (4),
    .N_RESULTS (8),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .adder_opstart (adder_opstart),
    .multi_opclear (multi_opclear),
    .prod          (pif.slave),
    .rAddr         (rAddr),
    .result        (result),
    .adder_opdone  (adder_opdone),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    pif.prod_valid = 1'b1;
    pif.prod_data  = d;
    tick();
    pif.prod_valid = 1'b0;
  endtask

  task automatic start_op();
    adder_opstart = 1'b1;
    tick();
    adder_opstart = 1'b0;
  endtask

  task automatic clear_op();
    multi_opclear = 1'b1;
    tick();
    multi_opclear = 1'b0;
  endtask

  task automatic read_mem(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] v);
    rAddr = a;
    tick();
    v = result;
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] v;
    #1 reset_n = 1'b0;
    #1;
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (pif.prod_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", pif.prod_ready); end
    checks++; if (adder_opdone !== 1'b0) begin failures++; $display("FAIL reset_opdone got=%b exp=0", adder_opdone); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checks++; if (pif.prod_ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0", pif.prod_ready); end
    start_op();
    checks++; if (pif.prod_ready !== 1'b1) begin failures++; $display("FAIL accum_ready got=%b exp=1", pif.prod_ready); end
    send(1); send(2); send(3); send(4);
    read_mem(0, v);
    checks++; if (v !== 32'd10) begin failures++; $display("FAIL pre_reset_mem0 got=%0d exp=10", v); end
    send(7); send(9);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL midop_reset_result got=%h exp=0", result); end
    checks++; if (pif.prod_ready !== 1'b0) begin failures++; $display("FAIL midop_reset_ready got=%b exp=0", pif.prod_ready); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (pif.prod_ready !== 1'b0) begin failures++; $display("FAIL post_reset_ready got=%b exp=0", pif.prod_ready); end
    read_mem(0, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL post_reset_mem0 got=%0d exp=0", v); end
    start_op();
    send(1); send(1); send(1); send(1);
    read_mem(0, v);
    checks++; if (v !== 32'd4) begin failures++; $display("FAIL partial_discard_mem0 got=%0d exp=4", v); end
    clear_op();
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] v;
    start_op();
    for (int k = 0; k < 32; k++) begin
      send(DATA_W'((k % 4) + 1));
      if (k == 30) begin
        checks++; if (adder_opdone !== 1'b0) begin failures++; $display("FAIL basic_early_opdone got=%b exp=0", adder_opdone); end
      end
    end
    checks++; if (adder_opdone !== 1'b1) begin failures++; $display("FAIL basic_opdone got=%b exp=1", adder_opdone); end
    checks++; if (pif.prod_ready !== 1'b0) begin failures++; $display("FAIL done_ready got=%b exp=0", pif.prod_ready); end
    for (int a = 0; a < 8; a++) begin
      read_mem(ADDR_W'(a), v);
      checks++; if (v !== 32'd10) begin failures++; $display("FAIL basic_mem%0d got=%0d exp=10", a, v); end
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL basic_overflow got=%b exp=0", overflow); end
    adder_opstart = 1'b1;
    tick(); tick();
    checks++; if (adder_opdone !== 1'b1) begin failures++; $display("FAIL done_opstart_held got=%b exp=1", adder_opdone); end
    adder_opstart = 1'b0;
    clear_op();
    checks++; if (adder_opdone !== 1'b0) begin failures++; $display("FAIL clear_opdone got=%b exp=0", adder_opdone); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] v;
    start_op();
    for (int k = 0; k < 4; k++) begin
      pif.prod_valid = 1'b1;
      pif.prod_data  = DATA_W'(5 + k);
      tick();
      pif.prod_valid = 1'b0;
      pif.prod_data  = 32'hDEAD_BEEF;
      tick();
    end
    read_mem(0, v);
    checks++; if (v !== 32'd26) begin failures++; $display("FAIL gaps_mem0 got=%0d exp=26", v); end
    read_mem(1, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL gaps_mem1 got=%0d exp=0", v); end
    clear_op();
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] v;
    start_op();
    send(32'hFFFF_FFFF);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    send(32'd2);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    send(0); send(0);
    read_mem(0, v);
    checks++; if (v !== 32'h0000_0001) begin failures++; $display("FAIL ovf_mem0 got=%h exp=00000001", v); end
    for (int k = 0; k < 28; k++) send(0);
    checks++; if (adder_opdone !== 1'b1) begin failures++; $display("FAIL ovf_opdone got=%b exp=1", adder_opdone); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky_done got=%b exp=1", overflow); end
    clear_op();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", overflow); end
  endtask

  task automatic test_clear();
    logic [DATA_W-1:0] v;
    start_op();
    for (int k = 0; k < 13; k++) send(1);
    pif.prod_valid = 1'b1;
    pif.prod_data  = 32'd100;
    multi_opclear  = 1'b1;
    #1;
    checks++; if (pif.prod_ready !== 1'b0) begin failures++; $display("FAIL clear_cycle_ready got=%b exp=0", pif.prod_ready); end
    tick();
    multi_opclear  = 1'b0;
    pif.prod_valid = 1'b0;
    #1;
    checks++; if (pif.prod_ready !== 1'b0) begin failures++; $display("FAIL clear_idle_ready got=%b exp=0", pif.prod_ready); end
    checks++; if (adder_opdone !== 1'b0) begin failures++; $display("FAIL clear_opdone got=%b exp=0", adder_opdone); end
    for (int a = 0; a < 8; a++) begin
      read_mem(ADDR_W'(a), v);
      checks++; if (v !== 32'd0) begin failures++; $display("FAIL clear_mem%0d got=%0d exp=0", a, v); end
    end
    start_op();
    send(2); send(2); send(2); send(2);
    read_mem(0, v);
    checks++; if (v !== 32'd8) begin failures++; $display("FAIL restart_mem0 got=%0d exp=8", v); end
    read_mem(1, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL restart_mem1 got=%0d exp=0", v); end
    clear_op();
  endtask

  task automatic test_priority();
    logic [DATA_W-1:0] v;
    multi_opclear = 1'b1;
    adder_opstart = 1'b1;
    tick();
    multi_opclear = 1'b0;
    #1;
    checks++; if (pif.prod_ready !== 1'b0) begin failures++; $display("FAIL prio_stay_idle got=%b exp=0", pif.prod_ready); end
    tick();
    checks++; if (pif.prod_ready !== 1'b1) begin failures++; $display("FAIL prio_to_accum got=%b exp=1", pif.prod_ready); end
    adder_opstart = 1'b0;
    for (int k = 0; k < 32; k++) send(DATA_W'(k + 1));
    checks++; if (adder_opdone !== 1'b1) begin failures++; $display("FAIL prio_opdone got=%b exp=1", adder_opdone); end
    rAddr = 3'd7;
    tick();
    checks++; if (result !== 32'd122) begin failures++; $display("FAIL done_read_mem7 got=%0d exp=122", result); end
    read_mem(3, v);
    checks++; if (v !== 32'd58) begin failures++; $display("FAIL done_read_mem3 got=%0d exp=58", v); end
    clear_op();
  endtask

  initial begin
    reset_n        = 1'b1;
    adder_opstart  = 1'b0;
    multi_opclear  = 1'b0;
    rAddr          = '0;
    pif.prod_valid = 1'b0;
    pif.prod_data  = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_clear();
    test_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
